// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter that serialises one byte per frame.
// Frame layout on tx_out: start (0), data bits 0..7 (LSB first),
// optional parity, then 1 or 2 stop bits (1). Every bit is held for
// CLK_DIV system clocks, counted by an internal divider, so no external
// baud tick is needed. A new byte is accepted from tx_start whenever the
// transmitter is idle, including the cycle in which tx_done pulses, which
// lets frames run back-to-back without an idle bit between them.

module uart_tx_frame #(
  parameter int CLK_DIV    = 16,  // system clocks per serial bit, 2..65535
  parameter int PARITY_EN  = 0,   // 1 inserts a parity bit after data bit 7
  parameter int PARITY_ODD = 0,   // parity sense: 0 = even, 1 = odd
  parameter int STOP_BITS  = 1    // number of stop bits, 1 or 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  // Last divider count of a bit; the bit (or state) advances on this count.
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  // Index of the final stop bit, counted on the shared bit counter.
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
  // Parity sense folded into a single bit for the XOR below.
  localparam logic        ODD_BIT   = (PARITY_ODD != 0);
  localparam bit          HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      r_state;
  logic [15:0] r_div;      // clocks elapsed within the current bit
  logic [2:0]  r_bit_cnt;  // data bit index in DATA, stop bit index in STOP
  logic [7:0]  r_shift;    // bits still to be sent, LSB goes out next
  logic [7:0]  r_data;     // untouched copy of the accepted byte, for parity
  logic        r_tx;
  logic        r_busy;
  logic        r_done;

  logic        w_bit_end;
  logic        w_parity;

  // End of the current bit period.
  assign w_bit_end = (r_div == DIV_LAST);

  // Parity comes from the latched byte so later data_in changes cannot leak in.
  assign w_parity  = (^r_data) ^ ODD_BIT;

  // Frame sequencer: state, divider, bit counter, shifter and all outputs.
  // NOTE: every register here uses <= so all of them update together from
  // the values seen before the edge; a blocking = would let later lines in
  // this block see half-updated state and change the hardware inferred.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked block and
    // only acts at an edge; it is deliberately not in the sensitivity list.
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // tx_done is a single-cycle pulse; only the last stop bit raises it.
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_tx  <= 1'b1;
          r_div <= '0;
          if (tx_start) begin
            r_shift   <= data_in;
            r_data    <= data_in;
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_START;
          end else begin
            r_busy <= 1'b0;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_state   <= S_DATA;
          end else begin
            r_div <= r_div + 16'd1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_div <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              if (HAS_PAR) begin
                r_tx    <= w_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_div <= r_div + 16'd1;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_state   <= S_STOP;
          end else begin
            r_div <= r_div + 16'd1;
          end
        end

        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            r_div <= '0;
            if (r_bit_cnt == STOP_LAST) begin
              r_bit_cnt <= '0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_div <= r_div + 16'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_div   <= '0;
        end
      endcase
    end
  end

  assign tx_out  = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter; the transmit-side counterpart to the receiver chain (start detect, bit sampling, parity check, stop check).
- Accepts a byte via a single-cycle start handshake and serialises it as: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Bit timing is derived from an internal clocks-per-bit counter, so no external baud tick is needed.
- Sits between the host-side byte source and the serial TX pin.

Parameters:
- CLK_DIV, 16, system clocks per serial bit; legal range 2..65535.
- PARITY_EN, 0, 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- tx_start  input  1  request to send data_in; sampled only when tx_busy=0.
- data_in  input  8  byte to transmit; captured on the accepted tx_start edge.
- tx_out  output  1  serial line, registered; idles high.
- tx_busy  output  1  high from acceptance until the last stop bit completes.
- tx_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset values: while rst_n=0 at a clk edge, the following take effect at that edge:
  - tx_out=1, tx_busy=0, tx_done=0
  - state=IDLE, bit counter=0, clock-divider counter=0, shift register=0
- Reset mid-frame: the frame is aborted and tx_out returns high at the next edge. No tx_done is issued.
- States:
  - IDLE → START → DATA → PARITY (only if PARITY_EN=1) → STOP → IDLE.
- IDLE:
  - tx_out=1, tx_busy=0.
  - If tx_start=1 at edge N: latch data_in into the shift register, clear the divider, and go to START.
  - tx_out=0 and tx_busy=1 are visible after edge N (latency one clock from request).
- Bit duration: every bit, including each stop bit, lasts exactly CLK_DIV cycles. The divider counts 0..CLK_DIV-1; the state or bit advances on the edge where divider==CLK_DIV-1.
- DATA:
  - Drives shift[0], then shifts right.
  - A 3-bit counter tracks bits 0..7; exit after bit 7.
- PARITY:
  - Value is the XOR-reduction of the latched byte, inverted when PARITY_ODD=1.
  - It is computed from the latched copy, never from the live data_in.
- STOP: drives 1 for STOP_BITS×CLK_DIV cycles.
- Completion: on the final edge of the last stop bit, go to IDLE, set tx_busy=0, and pulse tx_done=1 for one cycle.
- Frame length: (1+8+PARITY_EN+STOP_BITS)×CLK_DIV cycles, from acceptance to the tx_done edge.
- tx_start while busy: ignored and not queued. data_in changes during a frame do not affect it.
- Back-to-back frames: tx_start=1 in the cycle tx_done=1 is accepted, since tx_busy=0 then. The next start bit follows immediately, with no extra idle bit.
- No glitches: tx_out changes only on bit boundaries.

Test Plan:
1. Basic frame, no parity. CLK_DIV=4, PARITY_EN=0, STOP_BITS=1; pulse tx_start with data_in=0xA5.
   - tx_out sequence, 4 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
   - tx_busy is high for 40 cycles; tx_done pulses once at cycle 40; tx_out then stays high.
2. Parity sense. PARITY_EN=1; send data_in=0xA5, then 0x01.
   - With PARITY_ODD=0: parity bit 0 for 0xA5, 1 for 0x01.
   - With PARITY_ODD=1: parity bit 1 for 0xA5, 0 for 0x01.
   - Frame length is 44 cycles.
3. Two stop bits. STOP_BITS=2, data_in=0x00.
   - tx_out is low for 36 cycles, then high for 8.
   - tx_done pulses at cycle 44.
4. Busy ignore and back-to-back.
   - During the frame for 0x3C, assert tx_start with data_in=0xFF: this request is ignored and 0x3C is sent intact.
   - Assert tx_start=1 with data_in=0xC3 in the tx_done cycle: the next edge starts the 0xC3 start bit, with zero idle gap.
5. Reset mid-frame. Drop rst_n for 1 cycle during data bit 3.
   - tx_out=1, tx_busy=0 at that edge; no tx_done.
   - A following tx_start with 0x5A produces a clean, complete frame.
6. Large divider. CLK_DIV=16.
   - Each bit is exactly 16 cycles wide.
   - Edge-to-edge bit timing is checked by a bench monitor across a full 0x96 frame.
